// File: rtl/ndma_pkg.sv
// Shared types and defaults for the NDMA word-copy engine.
package ndma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } ndma_state_e;

  localparam int unsigned NdmaAddrIncDefault = 4;

endpackage

// File: rtl/ndma_xfer_engine.sv
// Single-channel DMA copy engine: reads one word over OBI, writes it back out,
// repeats len_i times, then pulses done_o.
module ndma_xfer_engine
  import ndma_pkg::*;
#(
  parameter int unsigned AddrInc = NdmaAddrIncDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] rd_addr_i,
  input  logic [31:0] wr_addr_i,
  input  logic [7:0]  len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic        err_i,
  input  logic [31:0] rdata_i,
  output ndma_state_e state_o
);

  // OBI handshake: req_o with addr_o/we_o/wdata_o is held stable until gnt_i;
  // the response (rvalid_i, err_i, rdata_i) is only taken in the *_WAIT state
  // after the grant cycle, so at most one transaction is ever outstanding.

  ndma_state_e state_q, state_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hold_q, hold_d;
  logic        err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    err_d     = err_q;
    req_o     = 1'b0;
    we_o      = 1'b0;
    addr_o    = '0;
    wdata_o   = '0;
    busy_o    = 1'b0;
    done_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (len_i == 8'd0) begin
            state_d = DONE;
          end else begin
            rd_addr_d = rd_addr_i;
            wr_addr_d = wr_addr_i;
            cnt_d     = len_i;
            state_d   = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        busy_o = 1'b1;
        req_o  = 1'b1;
        addr_o = rd_addr_q;
        if (gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        busy_o = 1'b1;
        if (rvalid_i) begin
          if (err_i) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            hold_d  = rdata_i;
            state_d = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        busy_o  = 1'b1;
        req_o   = 1'b1;
        we_o    = 1'b1;
        addr_o  = wr_addr_q;
        wdata_o = hold_q;
        if (gnt_i) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        busy_o = 1'b1;
        if (rvalid_i) begin
          if (err_i) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            // Addresses wrap naturally at 2^32.
            rd_addr_d = rd_addr_q + 32'(AddrInc);
            wr_addr_d = wr_addr_q + 32'(AddrInc);
            cnt_d     = cnt_q - 8'd1;
            state_d   = (cnt_q == 8'd1) ? DONE : RD_REQ;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_o   = err_q;
  assign be_o    = 4'hF;
  assign state_o = state_q;

endmodule

// File: tb/tb_ndma_xfer_engine.sv
// Randomized bench for ndma_xfer_engine: an OBI memory responder plus a
// transaction-level model of the expected bus traffic, timing and flags.
module tb_ndma_xfer_engine;
  import ndma_pkg::*;

  localparam int ADDR_INC = 4;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] rd_addr_i = '0;
  logic [31:0] wr_addr_i = '0;
  logic [7:0]  len_i = '0;
  logic        busy_o, done_o, err_o, req_o, we_o;
  logic [31:0] addr_o, wdata_o;
  logic [3:0]  be_o;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic        err_i = 1'b0;
  logic [31:0] rdata_i = '0;
  ndma_state_e state_o;

  initial forever #5 clk_i = ~clk_i;

  ndma_xfer_engine #(.AddrInc(ADDR_INC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .rd_addr_i(rd_addr_i), .wr_addr_i(wr_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .err_i(err_i), .rdata_i(rdata_i),
    .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [64:0] exp_q[$];   // {we, addr, wdata}
  logic [64:0] obs_q[$];
  logic [31:0] mem[logic [31:0]];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // ---------------- OBI responder ----------------
  int gnt_max = 0, rv_max = 0, force_gnt0 = -1, err_txn = -1, txn_idx = 0;
  bit stall_wr = 0;
  bit in_req = 0, resp_pending = 0, resp_err = 0, cur_we = 0;
  int gnt_wait = 0, resp_wait = 0;
  logic [31:0] cur_addr = '0, cur_wdata = '0, resp_data = '0;

  initial forever begin
    @(negedge clk_i);
    gnt_i = 0; rvalid_i = 0; err_i = 0; rdata_i = '0;
    if (!rst_ni) begin
      in_req = 0; resp_pending = 0;
    end else begin
      check("be_const", 72'(be_o), 72'h F);
      if (!req_o) check("idle_bus_zero", 72'({addr_o, wdata_o}), 72'h0);
      if (resp_pending) begin
        check("one_outstanding", 72'(req_o), 72'h0);
        if (resp_wait > 0) resp_wait--;
        else begin
          rvalid_i = 1; err_i = resp_err; rdata_i = resp_data; resp_pending = 0;
        end
      end else if (req_o) begin
        if (!in_req) begin
          in_req = 1; cur_we = we_o; cur_addr = addr_o; cur_wdata = wdata_o;
          gnt_wait = (txn_idx == 0 && force_gnt0 >= 0) ? force_gnt0 : $urandom_range(0, gnt_max);
        end else begin
          check("hold_addr", 72'(addr_o), 72'(cur_addr));
          check("hold_we", 72'(we_o), 72'(cur_we));
          check("hold_wdata", 72'(wdata_o), 72'(cur_wdata));
        end
        if (gnt_wait == 0 && !(stall_wr && cur_we)) begin
          gnt_i = 1; in_req = 0;
          obs_q.push_back({cur_we, cur_addr, cur_we ? cur_wdata : 32'h0});
          resp_pending = 1;
          resp_wait = $urandom_range(0, rv_max);
          resp_err = (txn_idx == err_txn);
          resp_data = cur_we ? 32'h0 : mem_rd(cur_addr);
          txn_idx++;
        end else if (gnt_wait > 0) gnt_wait--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    start_i = 0; rst_ni = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
  endtask

  // Model: word i reads rd+4i and writes mem[rd+4i] to wr+4i; bus transaction
  // e_txn (reads even, writes odd) errors and ends the transfer after it.
  task automatic run_xfer(input logic [31:0] rd, input logic [31:0] wr,
                          input logic [7:0] len, input int e_txn);
    int ntx, done_cyc, budget;
    bit seen, zero_wait;
    logic exp_err;
    logic [31:0] ra, wa;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 2 * int'(len); i++) begin
      if (e_txn >= 0 && i > e_txn) break;
      ra = rd + 32'(ADDR_INC * (i / 2));
      wa = wr + 32'(ADDR_INC * (i / 2));
      if (i % 2 == 0) exp_q.push_back({1'b0, ra, 32'h0});
      else exp_q.push_back({1'b1, wa, mem_rd(ra)});
    end
    ntx = exp_q.size();
    exp_err = (e_txn >= 0 && e_txn < 2 * int'(len));
    zero_wait = (gnt_max == 0 && rv_max == 0 && force_gnt0 < 0);
    err_txn = e_txn; txn_idx = 0;

    start_i = 1; rd_addr_i = rd; wr_addr_i = wr; len_i = len;
    seen = 0; done_cyc = 0;
    budget = 2 * int'(len) * (gnt_max + rv_max + 2) + (force_gnt0 > 0 ? force_gnt0 : 0) + 20;
    for (int c = 1; c <= budget && !seen; c++) begin
      @(negedge clk_i);
      start_i = 0;
      if (done_o) begin
        seen = 1; done_cyc = c;
        check("busy_at_done", 72'(busy_o), 72'h0);
        check("err_at_done", 72'(err_o), 72'(exp_err));
      end else begin
        check("busy_during", 72'(busy_o), 72'h1);
        if (c == 1) check("err_cleared", 72'(err_o), 72'h0);
        if ($urandom_range(0, 7) == 0) begin
          start_i = 1; rd_addr_i = $urandom; wr_addr_i = $urandom; len_i = 8'($urandom);
        end
      end
    end
    if (!seen) begin
      check("done_timeout", 72'h0, 72'h1);
      do_reset();
      return;
    end
    if (zero_wait) check("done_cycle", 72'(done_cyc), 72'(2 * ntx + 1));
    @(negedge clk_i);
    check("done_one_cycle", 72'(done_o), 72'h0);
    check("busy_after", 72'(busy_o), 72'h0);
    check("err_sticky", 72'(err_o), 72'(exp_err));
    check("txn_count", 72'(obs_q.size()), 72'(ntx));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check("txn", 72'(obs_q.pop_front()), 72'(exp_q.pop_front()));
  endtask

  task automatic set_bus(input int g, input int r, input int f);
    gnt_max = g; rv_max = r; force_gnt0 = f;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit found;
    rst_ni = 0;
    repeat (3) @(negedge clk_i);
    check("rst_req", 72'(req_o), 72'h0);
    check("rst_we", 72'(we_o), 72'h0);
    check("rst_addr", 72'(addr_o), 72'h0);
    check("rst_wdata", 72'(wdata_o), 72'h0);
    check("rst_flags", 72'({busy_o, done_o, err_o}), 72'h0);
    rst_ni = 1;
    @(negedge clk_i);

    set_bus(0, 0, -1);
    run_xfer(32'h1000, 32'h2000, 8'd3, -1);
    run_xfer(32'h1000, 32'h2000, 8'd0, -1);
    set_bus(0, 0, 5);
    run_xfer(32'h4000, 32'h5000, 8'd2, -1);
    set_bus(0, 0, -1);
    run_xfer(32'h6000, 32'h7000, 8'd4, 2);
    run_xfer(32'h6000, 32'h7000, 8'd1, -1);
    run_xfer(32'hFFFF_FFFC, 32'h3000, 8'd2, -1);
    run_xfer(32'h8000, 32'h9000, 8'd2, 1);

    // Reset asserted while a write request is stalled.
    stall_wr = 1; err_txn = -1; txn_idx = 0;
    start_i = 1; rd_addr_i = 32'hA000; wr_addr_i = 32'hB000; len_i = 8'd2;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk_i);
      start_i = 0;
      if (req_o && we_o) found = 1;
    end
    check("reach_wr_req", 72'(found), 72'h1);
    rst_ni = 0;
    #1;
    check("rst_mid_req", 72'(req_o), 72'h0);
    check("rst_mid_addr", 72'(addr_o), 72'h0);
    @(negedge clk_i);
    rst_ni = 1; stall_wr = 0;
    @(negedge clk_i);
    check("busy_after_rst", 72'(busy_o), 72'h0);
    run_xfer(32'hC000, 32'hD000, 8'd2, -1);

    // Longest transfer, zero-wait.
    run_xfer($urandom, $urandom, 8'd255, -1);

    for (int it = 0; it < 25; it++) begin
      logic [7:0] len;
      int e;
      len = 8'($urandom_range(0, 12));
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * int'(len)) : -1;
      set_bus($urandom_range(0, 3), $urandom_range(0, 3), -1);
      run_xfer($urandom, $urandom, len, e);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ndma_xfer_engine.md
NDMA_XFER_ENGINE -- requirements
Module: ndma_xfer_engine

Interface
REQ-001 Parameter: AddrInc, default 4, byte increment applied to both addresses per word.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 start_i  in  1  single-cycle transfer request from the DMA register block.
REQ-005 rd_addr_i  in  32  source byte address; sampled on accepted start.
REQ-006 wr_addr_i  in  32  destination byte address; sampled on accepted start.
REQ-007 len_i  in  8  word count; sampled on accepted start.
REQ-008 busy_o  out  1  high from the cycle after an accepted start until done_o.
REQ-009 done_o  out  1  one-cycle completion pulse.
REQ-010 err_o  out  1  sticky bus-error flag; cleared by the next accepted start.
REQ-011 req_o, we_o  out  1 each  OBI manager request and write enable.
REQ-012 addr_o, wdata_o  out  32 each  OBI address and write data; be_o  out  4  byte enables, always 4'hF.
REQ-013 gnt_i, rvalid_i, err_i  in  1 each  OBI grant, response valid, response error.
REQ-014 rdata_i  in  32  OBI read data, valid with rvalid_i.

Function
REQ-015 States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
REQ-016 Start is accepted only in IDLE; start_i in any other state is ignored with no side effects.
REQ-017 Accepted start with len_i==0: IDLE->DONE, no bus request issued, done_o high the following cycle.
REQ-018 Accepted start with len_i>0: latch addresses and count, clear err_o, go to RD_REQ.
REQ-019 RD_REQ: req_o=1, we_o=0, addr_o=current source address; remain until gnt_i, then go to RD_WAIT.
REQ-020 RD_WAIT: req_o=0; on rvalid_i capture rdata_i into a 32-bit holding register and go to WR_REQ.
REQ-021 WR_REQ: req_o=1, we_o=1, addr_o=current destination address, wdata_o=holding register; remain until gnt_i, then go to WR_WAIT.
REQ-022 WR_WAIT: on rvalid_i, add AddrInc to both addresses and decrement the count; go to DONE if the count reaches 0, else go to RD_REQ.
REQ-023 addr_o, we_o and wdata_o stay stable while req_o=1 and gnt_i=0; req_o is never withdrawn before grant.
REQ-024 Only one outstanding transaction at a time; rvalid_i is accepted only in the cycles after grant, never in the grant cycle.
REQ-025 rvalid_i with err_i=1 in RD_WAIT or WR_WAIT: set err_o, abandon the remaining words, go to DONE; no write is issued for a failed read.
REQ-026 DONE: done_o=1 for exactly one cycle, busy_o=0, next state IDLE.
REQ-027 Address increments wrap modulo 2^32; the count is 8-bit, so 255 words is the maximum transfer.
REQ-028 Throughput: 4 cycles per word minimum with zero-wait gnt_i and rvalid_i on the next cycle.
REQ-029 wdata_o=0 and addr_o=0 whenever req_o=0.

Reset
REQ-030 Asserting rst_ni low forces IDLE immediately, including mid-transfer; req_o drops without waiting for grant.
REQ-031 Reset values: all outputs 0; addresses, count and holding register 0; err_o 0.

Structure
REQ-032 Package ndma_pkg holds the state enum type and the default AddrInc constant.
REQ-033 No sub-module: FSM, address counters and the holding register are inline in one always_ff/always_comb pair.
REQ-034 Inputs connect directly to the DMA register block outputs; start_i is driven by its transfer-request pulse.

Verification
REQ-035 rd=0x1000, wr=0x2000, len=3, zero-wait memory -> reads at 0x1000/4/8, writes at 0x2000/4/8 with matching data, done_o at cycle 13 after start, err_o=0.
REQ-036 len=0 -> no req_o, done_o pulse one cycle after start, busy_o never high.
REQ-037 gnt_i held low 5 cycles on first read -> addr_o/we_o stable throughout, single read issued.
REQ-038 err_i on the second read of len=4 -> err_o=1, exactly one write issued, done_o pulses; the next start clears err_o.
REQ-039 rd=0xFFFFFFFC, len=2 -> second read address is 0x00000000.
REQ-040 rst_ni low during WR_REQ -> req_o=0 the same cycle; after release busy_o=0 and a new start completes normally.
